// File: rtl/rr_mux_pkg.sv
// Shared constants for the registered N-channel mux and its arbiter.
package rr_mux_pkg;
  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;
endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority search: first requester after ptr, wrapping NCH-1 -> 0.
module rr_arbiter #(
  parameter int NCH = 4,
  parameter int SW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [SW-1:0]  ptr,
  output logic           gnt_vld,
  output logic [SW-1:0]  gnt_idx
);
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    // Walk farthest-first so the closest requester after ptr is the last writer.
    for (int k = NCH; k >= 1; k--) begin
      int j;
      j = int'(ptr) + k;
      if (j >= NCH) j = j - NCH;
      if (req[j]) begin
        gnt_vld = 1'b1;
        gnt_idx = SW'(j);
      end
    end
  end
endmodule

// File: rtl/rr_mux_n.sv
// N-channel registered mux with valid/ready, manual-select or round-robin grant.
module rr_mux_n
  import rr_mux_pkg::*;
#(
  parameter int NCH = 4,
  parameter int W   = 2,
  parameter int SW  = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH*W-1:0] in_data,
  input  logic [NCH-1:0]   in_valid,
  output logic [NCH-1:0]   in_ready,
  input  logic             mode,
  input  logic [SW-1:0]    sel,
  output logic [W-1:0]     out_data,
  output logic [SW-1:0]    out_ch,
  output logic             out_valid,
  input  logic             out_ready
);
  logic [W-1:0]  data_q, data_d;
  logic [SW-1:0] ch_q, ch_d;
  logic          vld_q, vld_d;
  logic [SW-1:0] ptr_q, ptr_d;

  logic          rr_vld;
  logic [SW-1:0] rr_idx;
  logic          sel_ok;
  logic          grant;
  logic [SW-1:0] g;
  logic          load_en;
  logic          xfer;

  rr_arbiter #(.NCH(NCH), .SW(SW)) u_arb (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt_vld (rr_vld),
    .gnt_idx (rr_idx)
  );

  // sel may address a channel that does not exist when NCH is not a power of 2.
  assign sel_ok = (int'(sel) < NCH) ? in_valid[sel] : 1'b0;

  always_comb begin
    if (mode == MODE_RR) begin
      grant = rr_vld;
      g     = rr_idx;
    end else begin
      grant = sel_ok;
      g     = sel;
    end
  end

  assign load_en  = ~vld_q | out_ready;
  assign xfer     = grant & load_en;
  assign in_ready = xfer ? (NCH'(1) << g) : '0;

  always_comb begin
    data_d = data_q;
    ch_d   = ch_q;
    vld_d  = vld_q;
    ptr_d  = ptr_q;
    if (load_en) begin
      vld_d = grant;
      if (grant) begin
        data_d = in_data[int'(g)*W +: W];
        ch_d   = g;
      end
    end
    if (xfer && mode == MODE_RR) ptr_d = g;
  end

  // Pointer resets to the last channel so channel 0 wins the first round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      ch_q   <= '0;
      vld_q  <= 1'b0;
      ptr_q  <= SW'(NCH-1);
    end else begin
      data_q <= data_d;
      ch_q   <= ch_d;
      vld_q  <= vld_d;
      ptr_q  <= ptr_d;
    end
  end

  assign out_data  = data_q;
  assign out_ch    = ch_q;
  assign out_valid = vld_q;
endmodule
